// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index and the stall
// controller's state encoding.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    S_RUN,
    S_BUBBLE,
    S_IWAIT,
    S_DWAIT
  } lc3b_stall_state;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that
// takes priority over the increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && count != MAX)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline freeze/bubble/flush arbitration for the LC-3b core,
// with saturating stall/bubble/flush counters.
module hazard_stall_ctrl
  import lc3b_types::*;
#(
  parameter int LOADUSE_BUBBLES = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_req,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  lc3b_reg              id_sr1,
  input  logic                 id_sr1_used,
  input  lc3b_reg              id_sr2,
  input  logic                 id_sr2_used,
  input  lc3b_reg              ex_dest,
  input  logic                 ex_mem_read,
  input  logic                 mem_br_taken,
  input  logic                 cnt_clear,
  output logic                 stall_pipeline,
  output logic                 stall_front,
  output logic                 bubble_idex,
  output logic                 flush_front,
  output logic [CNT_WIDTH-1:0] cnt_stall,
  output logic [CNT_WIDTH-1:0] cnt_bubble,
  output logic [CNT_WIDTH-1:0] cnt_flush
);

  localparam logic [2:0] BUB_INIT = 3'(LOADUSE_BUBBLES - 1);
  localparam bit         MULTI    = LOADUSE_BUBBLES > 1;

  lc3b_stall_state state, state_n;
  lc3b_stall_state ret, ret_n;
  logic [2:0]      bcnt, bcnt_n;
  logic            kill, kill_n;

  logic hazard, dmiss, imiss, flush;
  logic sp, sf, bi, ff;

  assign hazard = ex_mem_read &
                  ((id_sr1_used & (id_sr1 == ex_dest)) |
                   (id_sr2_used & (id_sr2 == ex_dest)));
  assign dmiss  = dmem_req & ~dmem_resp;
  assign imiss  = imem_req & ~imem_resp;
  assign flush  = mem_br_taken & ~dmiss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      ret   <= S_RUN;
      bcnt  <= '0;
      kill  <= 1'b0;
    end else begin
      state <= state_n;
      ret   <= ret_n;
      bcnt  <= bcnt_n;
      kill  <= kill_n;
    end
  end

  always_comb begin
    state_n = state;
    ret_n   = ret;
    bcnt_n  = bcnt;
    kill_n  = kill;
    sp      = 1'b0;
    sf      = 1'b0;
    bi      = 1'b0;
    ff      = 1'b0;
    if (dmiss) begin
      sp = 1'b1;
      if (state == S_RUN || state == S_BUBBLE) begin
        state_n = S_DWAIT;
        ret_n   = state;
      end
    end else begin
      unique case (state)
        S_RUN: begin
          if (flush) begin
            ff = 1'b1;
            // fetch still in flight belongs to the squashed path
            if (imiss) begin
              state_n = S_IWAIT;
              kill_n  = 1'b1;
            end
          end else if (imiss) begin
            sf      = 1'b1;
            bi      = 1'b1;
            state_n = S_IWAIT;
          end else if (hazard) begin
            sf = 1'b1;
            bi = 1'b1;
            if (MULTI) begin
              state_n = S_BUBBLE;
              bcnt_n  = BUB_INIT;
            end
          end
        end
        S_BUBBLE: begin
          if (flush) begin
            ff      = 1'b1;
            state_n = S_RUN;
            bcnt_n  = '0;
          end else begin
            sf = 1'b1;
            bi = 1'b1;
            if (bcnt <= 3'd1) begin
              bcnt_n  = '0;
              state_n = S_RUN;
            end else begin
              bcnt_n = bcnt - 3'd1;
            end
          end
        end
        S_IWAIT: begin
          if (imiss) begin
            if (flush) begin
              ff     = 1'b1;
              kill_n = 1'b1;
            end else begin
              sf = 1'b1;
              bi = 1'b1;
            end
          end else begin
            state_n = S_RUN;
            ff      = kill | flush;
            kill_n  = 1'b0;
          end
        end
        S_DWAIT: begin
          ff = flush;
          if (flush || (ret == S_BUBBLE && bcnt == '0)) begin
            state_n = S_RUN;
            bcnt_n  = '0;
          end else begin
            state_n = ret;
          end
        end
        default: state_n = S_RUN;
      endcase
    end
  end

  assign stall_pipeline = sp & ~reset;
  assign stall_front    = sf & ~reset;
  assign bubble_idex    = bi & ~reset;
  assign flush_front    = ff & ~reset;

  sat_counter #(.W(CNT_WIDTH)) u_cnt_stall (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (stall_pipeline | stall_front),
    .count (cnt_stall)
  );

  sat_counter #(.W(CNT_WIDTH)) u_cnt_bubble (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (bubble_idex),
    .count (cnt_bubble)
  );

  sat_counter #(.W(CNT_WIDTH)) u_cnt_flush (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (flush_front),
    .count (cnt_flush)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default instance and a
// LOADUSE_BUBBLES=3 / CNT_WIDTH=4 instance share one stimulus.
module tb_hazard_stall_ctrl;
  import lc3b_types::*;

  logic    clk = 1'b0;
  logic    reset;
  logic    imem_req, imem_resp, dmem_req, dmem_resp;
  lc3b_reg id_sr1, id_sr2, ex_dest;
  logic    id_sr1_used, id_sr2_used, ex_mem_read;
  logic    mem_br_taken, cnt_clear;

  logic        a_sp, a_sf, a_bi, a_ff;
  logic [15:0] a_cs, a_cb, a_cf;
  logic        b_sp, b_sf, b_bi, b_ff;
  logic [3:0]  b_cs, b_cb, b_cf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl u_a (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_sr1(id_sr1), .id_sr1_used(id_sr1_used),
    .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .mem_br_taken(mem_br_taken), .cnt_clear(cnt_clear),
    .stall_pipeline(a_sp), .stall_front(a_sf),
    .bubble_idex(a_bi), .flush_front(a_ff),
    .cnt_stall(a_cs), .cnt_bubble(a_cb), .cnt_flush(a_cf)
  );

  hazard_stall_ctrl #(.LOADUSE_BUBBLES(3), .CNT_WIDTH(4)) u_b (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_sr1(id_sr1), .id_sr1_used(id_sr1_used),
    .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .mem_br_taken(mem_br_taken), .cnt_clear(cnt_clear),
    .stall_pipeline(b_sp), .stall_front(b_sf),
    .bubble_idex(b_bi), .flush_front(b_ff),
    .cnt_stall(b_cs), .cnt_bubble(b_cb), .cnt_flush(b_cf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a: {stall_pipeline, stall_front, bubble_idex, flush_front}
  function automatic logic [31:0] outs_a();
    return {28'd0, a_sp, a_sf, a_bi, a_ff};
  endfunction

  function automatic logic [31:0] outs_b();
    return {28'd0, b_sp, b_sf, b_bi, b_ff};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_req = 0; imem_resp = 0;
    dmem_req = 0; dmem_resp = 0;
    id_sr1 = 0; id_sr2 = 0; ex_dest = 0;
    id_sr1_used = 0; id_sr2_used = 0;
    ex_mem_read = 0; mem_br_taken = 0; cnt_clear = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic set_hazard(input logic used);
    ex_mem_read = 1; ex_dest = 3'd3;
    id_sr1 = 3'd3; id_sr1_used = used;
    id_sr2 = 3'd5; id_sr2_used = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    dmem_req = 1;
    set_hazard(1);
    #1;
    chk("reset_outs", outs_a(), 32'h0);
    chk("reset_cnt", {16'd0, a_cs}, 32'd0);
    do_reset();

    // single load-use bubble
    set_hazard(1);
    #4;
    chk("lu_outs", outs_a(), 32'b0110);
    tick();
    idle();
    #4;
    chk("lu_after", outs_a(), 32'h0);
    chk("lu_cnt_bubble", {16'd0, a_cb}, 32'd1);
    chk("lu_state", 32'(u_a.state), 32'(S_RUN));
    tick();

    // unused source operand: no hazard
    set_hazard(0);
    #4;
    chk("lu_unused", outs_a(), 32'h0);
    tick();

    // three bubbles
    do_reset();
    set_hazard(1);
    #4;
    chk("b3_c1", outs_b(), 32'b0110);
    tick();
    idle();
    #4;
    chk("b3_c2", outs_b(), 32'b0110);
    tick();
    #4;
    chk("b3_c3", outs_b(), 32'b0110);
    tick();
    #4;
    chk("b3_c4", outs_b(), 32'h0);
    chk("b3_cnt", {28'd0, b_cb}, 32'd3);
    tick();

    // flush in 2nd bubble cycle aborts
    do_reset();
    set_hazard(1);
    tick();
    idle();
    mem_br_taken = 1;
    #4;
    chk("b3f_flush", outs_b(), 32'b0001);
    tick();
    mem_br_taken = 0;
    #4;
    chk("b3f_after", outs_b(), 32'h0);
    chk("b3f_state", 32'(u_b.state), 32'(S_RUN));
    tick();

    // D-cache miss for 4 cycles with a hazard pending
    do_reset();
    set_hazard(1);
    dmem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk($sformatf("dm_stall%0d", i), outs_a(), 32'b1000);
      tick();
    end
    dmem_resp = 1;
    #4;
    chk("dm_resp", outs_a(), 32'h0);
    chk("dm_cnt", {16'd0, a_cs}, 32'd4);
    tick();
    dmem_req = 0; dmem_resp = 0;
    #4;
    chk("dm_bubble", outs_a(), 32'b0110);
    chk("dm_state", 32'(u_a.state), 32'(S_RUN));
    tick();

    // I-cache miss with a branch flush in cycle 2
    do_reset();
    imem_req = 1;
    #4;
    chk("im_c1", outs_a(), 32'b0110);
    tick();
    mem_br_taken = 1;
    #4;
    chk("im_c2_flush", outs_a(), 32'b0001);
    tick();
    mem_br_taken = 0;
    for (int i = 3; i <= 5; i++) begin
      #4;
      chk($sformatf("im_c%0d", i), outs_a(), 32'b0110);
      tick();
    end
    imem_resp = 1;
    #4;
    chk("im_resp_kill", outs_a(), 32'b0001);
    tick();
    imem_req = 0; imem_resp = 0;
    #4;
    chk("im_after", outs_a(), 32'h0);
    chk("im_cnt_flush", {16'd0, a_cf}, 32'd2);
    chk("im_state", 32'(u_a.state), 32'(S_RUN));
    tick();

    // 4-bit counter saturation and clear-over-increment
    do_reset();
    dmem_req = 1;
    repeat (20) tick();
    #4;
    chk("sat_cnt", {28'd0, b_cs}, 32'd15);
    chk("sat_cnt_wide", {16'd0, a_cs}, 32'd20);
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    #4;
    chk("clr_cnt", {28'd0, b_cs}, 32'd0);
    chk("clr_outs", outs_b(), 32'b1000);
    tick();

    // async reset in the middle of a D-cache wait
    do_reset();
    dmem_req = 1;
    tick();
    tick();
    chk("ar_pre", 32'(u_a.state), 32'(S_DWAIT));
    #2;
    reset = 1;
    #1;
    chk("ar_outs", outs_a(), 32'h0);
    chk("ar_cnt", {16'd0, a_cs}, 32'd0);
    chk("ar_state", 32'(u_a.state), 32'(S_RUN));
    idle();
    tick();
    reset = 0;
    tick();
    #4;
    chk("ar_post_state", 32'(u_a.state), 32'(S_RUN));
    chk("ar_post_cnt", {16'd0, a_cs}, 32'd0);
    chk("ar_post_outs", outs_a(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
